zcs_bridge_sequencer: RTL and testbench

//  Zero-current-switched H-bridge sequencer for the coil primary, inside controller_top.

---
 rtl/zcs_bridge_sequencer_if.sv | 31 +++
 rtl/zcs_bridge_sequencer.sv | 146 ++++++++++++++
 tb/tb_zcs_bridge_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zcs_bridge_sequencer_if.sv
// Bridge sequencer bundle: controller-side inputs and gate-drive / status outputs.
//   enable       interrupter on-time request
//   zcs_in       raw zero-current comparator (asynchronous)
//   gate1/gate4  phase A drives; gate2/gate3 phase B drives
//   running      sequencer active (not IDLE)
//   fault_pulse  one-clock strobe on lost-feedback abort
//   half_cycles  phase changes since the last IDLE exit (saturating)
// master = controller / stimulus side, slave = sequencer side.
interface zcs_bridge_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             zcs_in;
  logic             gate1;
  logic             gate2;
  logic             gate3;
  logic             gate4;
  logic             running;
  logic             fault_pulse;
  logic [CNT_W-1:0] half_cycles;

  modport master (
    output enable, zcs_in,
    input  gate1, gate2, gate3, gate4, running, fault_pulse, half_cycles
  );

  modport slave (
    input  enable, zcs_in,
    output gate1, gate2, gate3, gate4, running, fault_pulse, half_cycles
  );
endinterface

// File: rtl/zcs_bridge_sequencer.sv
// Zero-current-switched H-bridge sequencer for the coil primary.
// Alternates phase A (gate1+gate4) and phase B (gate2+gate3) on ZCS comparator
// edges, with a fixed dead gap between phases, a kick-start pulse when no
// feedback exists yet, edge blanking after each phase start and a lost-feedback
// timeout that aborts the burst.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  slave side of zcs_bridge_sequencer_if (enable, zcs_in in; gates,
//        running, fault_pulse, half_cycles out -- all registered)
module zcs_bridge_sequencer #(
  parameter int DEADTIME_CYCLES = 8,
  parameter int KICK_CYCLES     = 100,
  parameter int BLANK_CYCLES    = 20,
  parameter int TIMEOUT_CYCLES  = 400,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  zcs_bridge_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, KICK, DEAD, DRV_A, DRV_B, DRAIN} state_t;

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] timer, blank_cnt, half_cnt;
  logic             next_b, next_b_n;
  logic             abort, abort_n;
  logic             stop, stop_n;
  logic             fault_n, inc;
  logic             valid_edge;
  logic             g1, g2, g3, g4, run_q, fault_q;

  // s3 trails s2 in every state, so edges arriving in DEAD or inside the
  // blanking window are consumed and never seen later.
  assign valid_edge = (s2 != s3) && (blank_cnt >= CNT_W'(BLANK_CYCLES));

  always_comb begin
    state_n  = state;
    next_b_n = next_b;
    abort_n  = abort;
    stop_n   = stop;
    fault_n  = 1'b0;
    inc      = 1'b0;
    case (state)
      IDLE: begin
        abort_n = 1'b0;
        stop_n  = 1'b0;
        if (bus.enable) state_n = KICK;
      end
      KICK: begin
        // enable low only latches a shutdown; the pulse is never cut short
        if (!bus.enable) stop_n = 1'b1;
        if (valid_edge || timer == CNT_W'(KICK_CYCLES - 1)) begin
          state_n  = DEAD;
          next_b_n = 1'b1;
        end
      end
      DRV_A, DRV_B: begin
        if (!bus.enable) stop_n = 1'b1;
        // edge checked first so a coincident timeout is not a fault
        if (valid_edge) begin
          state_n  = DEAD;
          next_b_n = (state == DRV_A);
          inc      = 1'b1;
        end else if (timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = DEAD;
          abort_n = 1'b1;
          fault_n = 1'b1;
        end
      end
      DEAD: begin
        // once shutdown is latched, a re-raised enable cannot restart the bridge
        if (!bus.enable) stop_n = 1'b1;
        if (timer == CNT_W'(DEADTIME_CYCLES - 1))
          state_n = (stop_n || abort) ? DRAIN : (next_b ? DRV_B : DRV_A);
      end
      DRAIN: begin
        state_n = IDLE;
        abort_n = 1'b0;
        stop_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      timer     <= '0;
      blank_cnt <= '0;
      half_cnt  <= '0;
      next_b    <= 1'b0;
      abort     <= 1'b0;
      stop      <= 1'b0;
      g1        <= 1'b0;
      g2        <= 1'b0;
      g3        <= 1'b0;
      g4        <= 1'b0;
      run_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      s1     <= bus.zcs_in;
      s2     <= s1;
      s3     <= s2;
      state  <= state_n;
      next_b <= next_b_n;
      abort  <= abort_n;
      stop   <= stop_n;

      // phase/dead timer and blanking counter restart on every state change
      if (state_n != state || state == IDLE || state == DRAIN) begin
        timer     <= '0;
        blank_cnt <= '0;
      end else begin
        timer <= timer + 1'b1;
        if (blank_cnt < CNT_W'(BLANK_CYCLES)) blank_cnt <= blank_cnt + 1'b1;
      end

      if (state == IDLE && state_n == KICK) half_cnt <= '0;
      else if (inc && half_cnt != '1)       half_cnt <= half_cnt + 1'b1;

      // gates decoded from the next state: each phase is a single state, so
      // A and B can never be high together
      g1      <= (state_n == KICK) || (state_n == DRV_A);
      g4      <= (state_n == KICK) || (state_n == DRV_A);
      g2      <= (state_n == DRV_B);
      g3      <= (state_n == DRV_B);
      run_q   <= (state_n != IDLE);
      fault_q <= fault_n;
    end
  end

  assign bus.gate1       = g1;
  assign bus.gate2       = g2;
  assign bus.gate3       = g3;
  assign bus.gate4       = g4;
  assign bus.running     = run_q;
  assign bus.fault_pulse = fault_q;
  assign bus.half_cycles = half_cnt;

endmodule

// File: tb/tb_zcs_bridge_sequencer.sv
module tb_zcs_bridge_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] PH_A = 4'b1001;  // {gate1,gate2,gate3,gate4}
  localparam logic [3:0] PH_B = 4'b0110;
  localparam logic [3:0] OFF  = 4'b0000;

  zcs_bridge_sequencer_if #(.CNT_W(16)) b();
  zcs_bridge_sequencer dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  wire [3:0] gates = {b.gate1, b.gate2, b.gate3, b.gate4};

  // every cycle advance goes through here, so shoot-through is checked on all cycles
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (((b.gate1 | b.gate4) & (b.gate2 | b.gate3)) !== 1'b0) begin
      errors++;
      $display("FAIL shoot_through t=%0t gates=%b required no A&B overlap", $time, gates);
    end
  endtask

  // measure how long the current phase pattern holds; optional zcs toggles and
  // enable drop at given offsets from phase start (-1 = none)
  task automatic drive_phase(input logic [3:0] pat, input int t1, input int t2,
                             input int en_off, output int len);
    len = 0;
    while (gates == pat && len < 1000) begin
      if (len == t1 || len == t2) b.zcs_in = ~b.zcs_in;
      if (len == en_off) b.enable = 1'b0;
      len++;
      tick();
    end
  endtask

  // count all-low cycles while running; counts fault_pulse cycles seen
  task automatic count_dead(input int en_on, output int len, output int fcnt);
    len  = 0;
    fcnt = 0;
    while (gates == OFF && b.running === 1'b1 && len < 1000) begin
      if (b.fault_pulse === 1'b1) fcnt++;
      if (len == en_on) b.enable = 1'b1;
      len++;
      tick();
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b.enable = 1'b0;
    b.zcs_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b.zcs_in = ~b.zcs_in;
      tick();
    end
    b.zcs_in = 1'b0;
    checks++;
    if (gates !== OFF || b.running !== 1'b0 || b.fault_pulse !== 1'b0 || b.half_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs gates=%b run=%b fault=%b half=%0d required all 0",
               gates, b.running, b.fault_pulse, b.half_cycles);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (gates !== OFF || b.running !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset gates=%b run=%b required 0000/0", gates, b.running);
    end
  endtask

  task automatic test_startup();
    int len, fc;
    b.enable = 1'b1;
    tick();
    checks++;
    if (gates !== PH_A || b.running !== 1'b1 || b.half_cycles !== 16'd0) begin
      errors++;
      $display("FAIL startup_first gates=%b run=%b half=%0d required 1001/1/0",
               gates, b.running, b.half_cycles);
    end
    drive_phase(PH_A, -1, -1, -1, len);
    chk_int("kick_len", len, 100);
    count_dead(-1, len, fc);
    chk_int("kick_dead_len", len, 8);
    checks++;
    if (gates !== PH_B) begin
      errors++;
      $display("FAIL startup_phase_b gates=%b required %b", gates, PH_B);
    end
  endtask

  task automatic test_steady();
    int len, fc;
    logic [3:0] pat;
    pat = PH_B;
    for (int k = 1; k <= 3; k++) begin
      drive_phase(pat, 60, -1, -1, len);
      chk_int("steady_phase_len", len, 63);
      chk_int("steady_half", int'(b.half_cycles), k);
      count_dead(-1, len, fc);
      chk_int("steady_dead_len", len, 8);
      pat = (pat == PH_A) ? PH_B : PH_A;
      checks++;
      if (gates !== pat) begin
        errors++;
        $display("FAIL steady_alternate gates=%b required %b", gates, pat);
      end
    end
  endtask

  task automatic test_blanking();
    int len, fc;
    drive_phase(PH_A, 10, 40, -1, len);
    chk_int("blank_phase_len", len, 43);
    chk_int("blank_half", int'(b.half_cycles), 4);
    count_dead(-1, len, fc);
    chk_int("blank_dead_len", len, 8);
  endtask

  task automatic test_edge_vs_timeout();
    int len, fc;
    drive_phase(PH_B, 397, -1, -1, len);
    chk_int("tie_phase_len", len, 400);
    count_dead(-1, len, fc);
    chk_int("tie_fault_cnt", fc, 0);
    chk_int("tie_dead_len", len, 8);
    chk_int("tie_half", int'(b.half_cycles), 5);
    checks++;
    if (gates !== PH_A) begin
      errors++;
      $display("FAIL tie_continues gates=%b required %b", gates, PH_A);
    end
  endtask

  task automatic test_lost_feedback();
    int len, fc;
    drive_phase(PH_A, -1, -1, -1, len);
    chk_int("lost_phase_len", len, 400);
    checks++;
    if (b.fault_pulse !== 1'b1 || gates !== OFF) begin
      errors++;
      $display("FAIL lost_fault_edge fault=%b gates=%b required 1/0000", b.fault_pulse, gates);
    end
    chk_int("lost_half_held", int'(b.half_cycles), 5);
    count_dead(-1, len, fc);
    chk_int("lost_fault_cnt", fc, 1);
    chk_int("lost_dead_drain_len", len, 9);
    checks++;
    if (b.running !== 1'b0 || gates !== OFF) begin
      errors++;
      $display("FAIL lost_idle run=%b gates=%b required 0/0000", b.running, gates);
    end
    // enable still high: restarts from IDLE with a fresh kick
    tick();
    checks++;
    if (gates !== PH_A || b.half_cycles !== 16'd0 || b.running !== 1'b1) begin
      errors++;
      $display("FAIL restart gates=%b half=%0d run=%b required 1001/0/1",
               gates, b.half_cycles, b.running);
    end
  endtask

  task automatic test_kick_edge();
    int len, fc;
    drive_phase(PH_A, 50, -1, -1, len);
    chk_int("kick_edge_len", len, 53);
    count_dead(-1, len, fc);
    chk_int("kick_edge_dead", len, 8);
  endtask

  task automatic test_turnoff();
    int len, fc;
    drive_phase(PH_B, 60, -1, 20, len);
    chk_int("turnoff_phase_len", len, 63);
    chk_int("turnoff_half", int'(b.half_cycles), 1);
    // enable re-raised during the dead gap must not restart the bridge
    count_dead(3, len, fc);
    chk_int("turnoff_dead_drain_len", len, 9);
    checks++;
    if (b.running !== 1'b0 || gates !== OFF) begin
      errors++;
      $display("FAIL turnoff_idle run=%b gates=%b required 0/0000", b.running, gates);
    end
    b.enable = 1'b0;
    tick();
    tick();
    checks++;
    if (b.running !== 1'b0 || gates !== OFF) begin
      errors++;
      $display("FAIL turnoff_stays_idle run=%b gates=%b required 0/0000", b.running, gates);
    end
  endtask

  task automatic test_reset_mid();
    int len;
    b.enable = 1'b1;
    tick();
    drive_phase(PH_A, 30, -1, -1, len);
    for (int i = 0; i < 12; i++) tick();   // now in phase B
    checks++;
    if (gates !== PH_B) begin
      errors++;
      $display("FAIL mid_pre_reset gates=%b required %b", gates, PH_B);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gates !== OFF || b.running !== 1'b0 || b.half_cycles !== 16'd0 || b.fault_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset gates=%b run=%b half=%0d fault=%b required all 0",
               gates, b.running, b.half_cycles, b.fault_pulse);
    end
    rst = 1'b0;
    b.enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_steady();
    test_blanking();
    test_edge_vs_timeout();
    test_lost_feedback();
    test_kick_edge();
    test_turnoff();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
